// File: rtl/pipe_perf_monitor.sv
// Pipeline event monitor: saturating cycle/stall/flush/retire counters and last PC,
// with snapshot shadows, a registered read port and a sticky cycle-budget halt.
module pipe_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30,
  parameter int PC_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             eq_i,
  input  logic             retire_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             clr_i,
  input  logic             snap_i,
  input  logic [2:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             halt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HALT_AT = CNT_W'(MAX_CYCLES);

  logic [CNT_W-1:0] cycle_q,  cycle_d;
  logic [CNT_W-1:0] stall_q,  stall_d;
  logic [CNT_W-1:0] flush_q,  flush_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             halt_q,   halt_d;

  logic [CNT_W-1:0] sh_cycle_q,  sh_cycle_d;
  logic [CNT_W-1:0] sh_stall_q,  sh_stall_d;
  logic [CNT_W-1:0] sh_flush_q,  sh_flush_d;
  logic [CNT_W-1:0] sh_retire_q, sh_retire_d;
  logic [PC_W-1:0]  sh_pc_q,     sh_pc_d;
  logic [CNT_W-1:0] rd_data_q,   rd_data_d;

  logic stall_ev;
  logic flush_ev;
  logic cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    sat_inc = (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    stall_ev = hazard_i & ~jump_i & ~branch_i;
    flush_ev = jump_i | (branch_i & eq_i);
    cnt_en   = start_i & ~halt_q & ~clr_i;
  end

  always_comb begin
    cycle_d   = cycle_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    retire_d  = retire_q;
    last_pc_d = last_pc_q;
    halt_d    = halt_q;
    if (clr_i) begin
      cycle_d   = '0;
      stall_d   = '0;
      flush_d   = '0;
      retire_d  = '0;
      last_pc_d = '0;
      halt_d    = 1'b0;
    end else if (cnt_en) begin
      cycle_d   = sat_inc(cycle_q, 1'b1);
      stall_d   = sat_inc(stall_q, stall_ev);
      flush_d   = sat_inc(flush_q, flush_ev);
      retire_d  = sat_inc(retire_q, retire_i);
      last_pc_d = pc_i;
      halt_d    = (MAX_CYCLES != 0) && (cycle_d == HALT_AT);
    end
  end

  // Shadows capture the pre-edge live values, so snap+clr keeps the old counts.
  always_comb begin
    sh_cycle_d  = snap_i ? cycle_q   : sh_cycle_q;
    sh_stall_d  = snap_i ? stall_q   : sh_stall_q;
    sh_flush_d  = snap_i ? flush_q   : sh_flush_q;
    sh_retire_d = snap_i ? retire_q  : sh_retire_q;
    sh_pc_d     = snap_i ? last_pc_q : sh_pc_q;
  end

  always_comb begin
    rd_data_d = '0;
    case (rd_sel_i)
      3'd0:    rd_data_d = sh_cycle_q;
      3'd1:    rd_data_d = sh_stall_q;
      3'd2:    rd_data_d = sh_flush_q;
      3'd3:    rd_data_d = sh_retire_q;
      3'd4:    rd_data_d = CNT_W'(sh_pc_q);
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q     <= '0;
      stall_q     <= '0;
      flush_q     <= '0;
      retire_q    <= '0;
      last_pc_q   <= '0;
      halt_q      <= 1'b0;
      sh_cycle_q  <= '0;
      sh_stall_q  <= '0;
      sh_flush_q  <= '0;
      sh_retire_q <= '0;
      sh_pc_q     <= '0;
      rd_data_q   <= '0;
    end else begin
      cycle_q     <= cycle_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      retire_q    <= retire_d;
      last_pc_q   <= last_pc_d;
      halt_q      <= halt_d;
      sh_cycle_q  <= sh_cycle_d;
      sh_stall_q  <= sh_stall_d;
      sh_flush_q  <= sh_flush_d;
      sh_retire_q <= sh_retire_d;
      sh_pc_q     <= sh_pc_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign halt_o    = halt_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed scenarios plus random traffic checked
// against an array-based reference model; a narrow instance exercises saturation.
module tb_pipe_perf_monitor;

  localparam longint unsigned CMAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hazard, jump, branch, eq, retire, clr, snap;
  logic [2:0]  sel;
  logic [31:0] pc;
  logic [31:0] rd_data;
  logic        halt;

  logic        s_start, s_snap;
  logic [2:0]  s_sel;
  logic [3:0]  s_rd;
  logic        s_halt;

  int checks = 0;
  int errors = 0;

  longint unsigned m_live[5];
  longint unsigned m_sh[5];
  longint unsigned m_rd;
  bit              m_halt;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30), .PC_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_i(hazard), .jump_i(jump),
    .branch_i(branch), .eq_i(eq), .retire_i(retire), .pc_i(pc), .clr_i(clr),
    .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd_data), .halt_o(halt)
  );

  pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0), .PC_W(32)) dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .hazard_i(1'b0), .jump_i(1'b0),
    .branch_i(1'b0), .eq_i(1'b0), .retire_i(s_start), .pc_i(32'h0), .clr_i(1'b0),
    .snap_i(s_snap), .rd_sel_i(s_sel), .rd_data_o(s_rd), .halt_o(s_halt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned add_sat(input longint unsigned v, input bit b);
    return (v + b > CMAX) ? CMAX : v + b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_live[i] = 0;
      m_sh[i]   = 0;
    end
    m_rd   = 0;
    m_halt = 0;
  endtask

  task automatic model_edge();
    longint unsigned nrd;
    bit st, fl;
    nrd = (sel < 3'd5) ? m_sh[sel] : 0;
    if (snap) for (int i = 0; i < 5; i++) m_sh[i] = m_live[i];
    if (clr) begin
      for (int i = 0; i < 5; i++) m_live[i] = 0;
      m_halt = 0;
    end else if (start && !m_halt) begin
      st = hazard && !jump && !branch;
      fl = jump || (branch && eq);
      m_live[0] = add_sat(m_live[0], 1'b1);
      m_live[1] = add_sat(m_live[1], st);
      m_live[2] = add_sat(m_live[2], fl);
      m_live[3] = add_sat(m_live[3], retire);
      m_live[4] = longint'(pc);
      if (m_live[0] == 30) m_halt = 1;
    end
    m_rd = nrd;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".rd"}, rd_data, m_rd);
    chk({tag, ".halt"}, halt, m_halt);
  endtask

  task automatic idle();
    start = 0; hazard = 0; jump = 0; branch = 0; eq = 0; retire = 0;
    clr = 0; snap = 0; sel = 0; pc = 0;
    s_start = 0; s_snap = 0; s_sel = 0;
  endtask

  initial begin
    int n;
    idle();
    model_reset();
    rst = 1;
    #12;
    chk("rst.rd", rd_data, 0);
    chk("rst.halt", halt, 0);
    chk("rst.small_rd", s_rd, 0);
    @(negedge clk);
    rst = 0;

    // 10 idle counted edges
    start = 1;
    repeat (10) step("run10");
    start = 0; snap = 1; step("snap1");
    snap = 0; sel = 0; step("rd_cyc");
    chk("cycle10", rd_data, 10);
    sel = 1; step("rd_stall"); chk("stall0", rd_data, 0);
    sel = 2; step("rd_flush"); chk("flush0", rd_data, 0);
    sel = 3; step("rd_ret");   chk("retire0", rd_data, 0);

    // hazard/jump/branch decode
    sel = 0; start = 1; hazard = 1;
    step("haz1");
    branch = 1; step("haz_br_ne");
    branch = 0; step("haz2");
    hazard = 0; jump = 1; step("jump");
    jump = 0; branch = 1; eq = 1; step("br_eq");
    branch = 0; eq = 0; start = 0; snap = 1; step("snap2");
    snap = 0; sel = 1; step("rd_stall2"); chk("stall2", rd_data, 2);
    sel = 2; step("rd_flush2"); chk("flush2", rd_data, 2);

    // retire pulses and last PC
    start = 1; retire = 1;
    for (int i = 0; i < 7; i++) begin
      pc = (i == 6) ? 32'h0000_0040 : $urandom;
      step("retire");
    end
    retire = 0; start = 0; snap = 1; step("snap3");
    snap = 0; sel = 3; step("rd_ret7"); chk("retire7", rd_data, 7);
    sel = 4; step("rd_pc"); chk("last_pc", rd_data, 32'h40);

    // run into the cycle budget
    sel = 0; start = 1; n = 0;
    while (!m_halt && n < 40) begin
      step("to_halt");
      n++;
    end
    chk("halt_rise", halt, 1);
    repeat (3) step("halted");
    start = 0; snap = 1; step("snap4");
    snap = 0; step("rd_frozen"); chk("cycle_frozen30", rd_data, 30);
    clr = 1; step("clr");
    chk("halt_cleared", halt, 0);
    clr = 0; start = 1; step("restart");
    start = 0; snap = 1; step("snap5");
    snap = 0; step("rd_restart"); chk("cycle_restart1", rd_data, 1);

    // snap together with clr
    clr = 1; step("clr2");
    clr = 0; start = 1;
    repeat (12) step("run12");
    snap = 1; clr = 1; step("snap_clr");
    snap = 0; clr = 0; start = 0; step("rd_snapclr"); chk("snapclr_shadow12", rd_data, 12);
    snap = 1; step("snap6");
    snap = 0; step("rd_live0"); chk("snapclr_live0", rd_data, 0);

    // random traffic against the model
    repeat (300) begin
      start  = ($urandom_range(0, 3) != 0);
      hazard = $urandom_range(0, 1);
      jump   = ($urandom_range(0, 3) == 0);
      branch = $urandom_range(0, 1);
      eq     = $urandom_range(0, 1);
      retire = $urandom_range(0, 1);
      pc     = $urandom;
      clr    = ($urandom_range(0, 15) == 0);
      snap   = ($urandom_range(0, 3) == 0);
      sel    = 3'($urandom_range(0, 7));
      step("rand");
    end

    // saturation on a 4-bit instance with halt disabled
    idle();
    s_start = 1;
    repeat (17) step("sat_run");
    s_start = 0; s_snap = 1; step("sat_snap");
    s_snap = 0; s_sel = 0; step("sat_rd0");
    chk("sat_cycle", s_rd, 4'hF);
    s_sel = 3; step("sat_rd3");
    chk("sat_retire", s_rd, 4'hF);
    chk("sat_no_halt", s_halt, 0);

    // asynchronous reset mid-cycle
    start = 1; sel = 0; n = 0;
    while (!m_halt && n < 40) begin
      step("pre_rst");
      n++;
    end
    start = 0; snap = 1; step("pre_rst_snap");
    snap = 0; step("pre_rst_rd");
    chk("pre_rst_rd30", rd_data, 30);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_rst.rd", rd_data, 0);
    chk("async_rst.halt", halt, 0);
    chk("async_rst.small_rd", s_rd, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    start = 1; step("post_rst_run");
    start = 0; snap = 1; step("post_rst_snap");
    snap = 0; step("post_rst_rd");
    chk("post_rst_cycle1", rd_data, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
